// File: rtl/serial_adder_n_if.sv
// Operand/result bundle for serial_adder_n: Start/Busy/Done handshake plus data.
interface serial_adder_n_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic             Sub;
    logic             Cin;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output Start, Sub, Cin, A, B,
        input  Busy, Done, Sum, Cout, Ovf
    );

    modport slave (
        input  Start, Sub, Cin, A, B,
        output Busy, Done, Sum, Cout, Ovf
    );
endinterface

// File: rtl/serial_adder_n.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through one slice and a
// registered carry. WIDTH >= 2 and DIGIT must divide WIDTH.
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_adder_n_if.slave  bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_res, r_sum;
    logic             r_carry, r_cout, r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic [DIGIT:0]   w_slice;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_last, w_accept, w_c_msb;

    assign w_slice   = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
    assign w_res_nxt = (r_res >> DIGIT) | (WIDTH'(w_slice[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign w_last    = (r_cnt == CNT_W'(STEPS - 1));
    // Carry into the slice MSB recovered from its sum bit and the two operand bits.
    assign w_c_msb   = w_slice[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
    assign w_accept  = (r_state != RUN) && bus.Start;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.Start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = bus.Start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            // Subtract is A + ~B + 1; Cin is ignored in that mode.
            r_a     <= bus.A;
            r_b     <= bus.Sub ? ~bus.B : bus.B;
            r_carry <= bus.Sub ? 1'b1 : bus.Cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_res   <= w_res_nxt;
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_slice[DIGIT];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_sum  <= w_res_nxt;
                r_cout <= w_slice[DIGIT];
                r_ovf  <= w_c_msb ^ w_slice[DIGIT];
            end
        end
    end

    assign bus.Busy = (r_state == RUN);
    assign bus.Done = (r_state == DONE);
    assign bus.Sum  = r_sum;
    assign bus.Cout = r_cout;
    assign bus.Ovf  = r_ovf;
endmodule
